// File: rtl/cen_gen.sv
// cen_gen: N-channel fractional clock-enable generator with PLL-lock reset
// sequencing. Each channel runs a phase accumulator; its carry-out becomes a
// single-cycle enable pulse at rate inc/2^ACC_W of clk. The core is held in
// reset until the synchronised PLL lock has been stable for RST_HOLD cycles.
//
// Ports:
//   clk        - system clock (PLL output)
//   rst_n      - asynchronous active-low reset
//   locked     - PLL lock, asynchronous to clk
//   inc        - per-channel increments, channel i at [i*ACC_W +: ACC_W]
//   inc_load   - single-cycle request to apply new increments atomically
//   clr_lost   - clears the sticky lost flag
//   cen        - per-channel single-cycle enable pulses
//   core_reset - active-high reset to the rest of the core
//   lost       - sticky flag: lock dropped after leaving WAIT_LOCK
module cen_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        locked,
    input  logic [CHANNELS*ACC_W-1:0]   inc,
    input  logic                        inc_load,
    input  logic                        clr_lost,
    output logic [CHANNELS-1:0]         cen,
    output logic                        core_reset,
    output logic                        lost
);

    localparam int unsigned CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic                sync1_q;
    logic                sync2_q;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [ACC_W-1:0]    acc_q  [CHANNELS];
    logic [ACC_W-1:0]    acc_d  [CHANNELS];
    logic [ACC_W-1:0]    shad_q [CHANNELS];
    logic [ACC_W-1:0]    shad_d [CHANNELS];
    logic [ACC_W:0]      sum    [CHANNELS];
    logic [CHANNELS-1:0] cen_q, cen_d;
    logic                core_reset_q, core_reset_d;
    logic                lost_q, lost_d;
    logic                run_ok;

    // Next-state, counters, flags and per-channel accumulator update
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        lost_d     = lost_q;

        case (state_q)
            WAIT_LOCK: begin
                if (sync2_q) state_d = HOLD;
            end
            HOLD: begin
                if (!sync2_q)                                   state_d = WAIT_LOCK;
                else if (hold_cnt_q == CNT_W'(RST_HOLD - 1))    state_d = RUN;
            end
            RUN: begin
                if (!sync2_q) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Counter only advances while staying in HOLD; cleared otherwise
        if (state_q == HOLD && state_d == HOLD) hold_cnt_d = hold_cnt_q + CNT_W'(1);

        // Set on lock loss outranks clear
        if (state_q != WAIT_LOCK && !sync2_q) lost_d = 1'b1;
        else if (clr_lost)                    lost_d = 1'b0;

        core_reset_d = (state_d != RUN);

        // Pulses only when in RUN now and staying in RUN through this edge
        run_ok = (state_q == RUN) && (state_d == RUN);

        for (int i = 0; i < int'(CHANNELS); i++) begin
            shad_d[i] = shad_q[i];
            acc_d[i]  = '0;
            cen_d[i]  = 1'b0;
            sum[i]    = '0;
            if (state_q != RUN || inc_load) shad_d[i] = inc[i*ACC_W +: ACC_W];
            if (run_ok && !inc_load) begin
                sum[i]   = {1'b0, acc_q[i]} + {1'b0, shad_q[i]};
                acc_d[i] = sum[i][ACC_W-1:0];
                cen_d[i] = sum[i][ACC_W];
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= WAIT_LOCK;
            hold_cnt_q   <= '0;
            cen_q        <= '0;
            core_reset_q <= 1'b1;
            lost_q       <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                acc_q[i]  <= '0;
                shad_q[i] <= '0;
            end
        end else begin
            sync1_q      <= locked;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cen_q        <= cen_d;
            core_reset_q <= core_reset_d;
            lost_q       <= lost_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                acc_q[i]  <= acc_d[i];
                shad_q[i] <= shad_d[i];
            end
        end
    end

    assign cen        = cen_q;
    assign core_reset = core_reset_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_cen_gen.sv
module tb_cen_gen;

    localparam int unsigned CH = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned RH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              locked;
    logic [CH*AW-1:0]  inc;
    logic              inc_load;
    logic              clr_lost;
    logic [CH-1:0]     cen;
    logic              core_reset;
    logic              lost;

    int total = 0;
    int bad   = 0;

    cen_gen #(.CHANNELS(CH), .ACC_W(AW), .RST_HOLD(RH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .inc        (inc),
        .inc_load   (inc_load),
        .clr_lost   (clr_lost),
        .cen        (cen),
        .core_reset (core_reset),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] k0;
        logic [3:0] k1;
        int         cnt0;
        int         cnt1;
        int         first0;
        int         first1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for core_reset to fall; n = edges counted, -1 on timeout
    task automatic wait_release(output int n, output logic seen);
        logic done;
        n    = -1;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (!done) begin
                @(negedge clk);
                if (|cen) seen = 1'b1;
                if (!core_reset) begin
                    n    = i;
                    done = 1'b1;
                end
            end
        end
    endtask

    // Apply new increments with inc_load, then scramble inc to prove shadows hold
    task automatic load_rate(input logic [3:0] k0, input logic [3:0] k1);
        @(negedge clk);
        inc      = {k1, k0};
        inc_load = 1'b1;
        @(negedge clk);
        chk("load_edge_cen", 32'(cen), 32'd0);
        inc_load = 1'b0;
        inc      = ~{k1, k0};
    endtask

    task automatic run_window(input int n, output int c0, output int c1,
                              output int f0, output int f1,
                              output logic [31:0] m0, output logic [31:0] m1);
        c0 = 0; c1 = 0; f0 = 0; f1 = 0; m0 = '0; m1 = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (cen[0]) begin
                c0++;
                if (f0 == 0) f0 = i;
                if (i <= 32) m0[i-1] = 1'b1;
            end
            if (cen[1]) begin
                c1++;
                if (f1 == 0) f1 = i;
                if (i <= 32) m1[i-1] = 1'b1;
            end
        end
    endtask

    initial begin
        int          n, c0, c1, f0, f1;
        logic        seen;
        logic [31:0] m0, m1;

        // k0, k1, pulses in 32 cycles (ch0, ch1), first pulse offset (0 = none)
        vecs[0] = '{k0: 4'd4,  k1: 4'd0, cnt0: 8,  cnt1: 0,  first0: 4, first1: 0};
        vecs[1] = '{k0: 4'd3,  k1: 4'd0, cnt0: 6,  cnt1: 0,  first0: 6, first1: 0};
        vecs[2] = '{k0: 4'd2,  k1: 4'd8, cnt0: 4,  cnt1: 16, first0: 8, first1: 2};
        vecs[3] = '{k0: 4'd8,  k1: 4'd2, cnt0: 16, cnt1: 4,  first0: 2, first1: 8};
        vecs[4] = '{k0: 4'd15, k1: 4'd1, cnt0: 30, cnt1: 2,  first0: 2, first1: 16};
        vecs[5] = '{k0: 4'd9,  k1: 4'd5, cnt0: 18, cnt1: 10, first0: 2, first1: 4};

        rst_n    = 1'b0;
        locked   = 1'b0;
        inc      = 8'h04;
        inc_load = 1'b0;
        clr_lost = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_core_reset", 32'(core_reset), 32'd1);
        chk("reset_cen",        32'(cen),        32'd0);
        chk("reset_lost",       32'(lost),       32'd0);

        // Lock sequencing: locked rises at cycle 10
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        chk("prelock_core_reset", 32'(core_reset), 32'd1);
        locked = 1'b1;
        wait_release(n, seen);
        chk("lock_release_edges", 32'(n), 32'(RH + 3));
        chk("lock_cen_quiet",     32'(seen), 32'd0);

        // Integer divide by 4 from release
        run_window(100, c0, c1, f0, f1, m0, m1);
        chk("div4_first", 32'(f0), 32'd4);
        chk("div4_count", 32'(c0), 32'd25);
        chk("div4_ch1",   32'(c1), 32'd0);

        // Fractional 3/16: pulses at 6,11,16 then repeating every 16
        load_rate(4'd3, 4'd0);
        run_window(32, c0, c1, f0, f1, m0, m1);
        chk("frac3_mask", m0, 32'h8420_8420);
        chk("frac3_ch1",  32'(c1), 32'd0);

        // Atomic reload: ch0=2 (every 8), ch1=8 (every 2), coincident at +8
        load_rate(4'd2, 4'd8);
        run_window(32, c0, c1, f0, f1, m0, m1);
        chk("reload_mask0", m0, 32'h8080_8080);
        chk("reload_mask1", m1, 32'hAAAA_AAAA);

        for (int v = 0; v < 6; v++) begin
            load_rate(vecs[v].k0, vecs[v].k1);
            run_window(32, c0, c1, f0, f1, m0, m1);
            chk($sformatf("vec%0d_cnt0", v),   32'(c0), 32'(vecs[v].cnt0));
            chk($sformatf("vec%0d_cnt1", v),   32'(c1), 32'(vecs[v].cnt1));
            chk($sformatf("vec%0d_first0", v), 32'(f0), 32'(vecs[v].first0));
            chk($sformatf("vec%0d_first1", v), 32'(f1), 32'(vecs[v].first1));
        end

        // Lock drop for one cycle mid-RUN
        inc = 8'h88;
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        chk("drop_a0_core_reset", 32'(core_reset), 32'd0);
        @(negedge clk);
        chk("drop_a1_core_reset", 32'(core_reset), 32'd0);
        @(negedge clk);
        chk("drop_core_reset", 32'(core_reset), 32'd1);
        chk("drop_cen",        32'(cen),        32'd0);
        chk("drop_lost",       32'(lost),       32'd1);
        wait_release(n, seen);
        chk("relock_edges",    32'(n),    32'(RH + 1));
        chk("relock_cen_quiet", 32'(seen), 32'd0);
        chk("relock_lost_sticky", 32'(lost), 32'd1);

        @(negedge clk);
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        chk("clr_lost", 32'(lost), 32'd0);

        // Drop with clr_lost held through the set edge: set wins
        @(negedge clk);
        locked   = 1'b0;
        clr_lost = 1'b1;
        @(negedge clk);
        locked = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("drop_clr_lost", 32'(lost), 32'd1);
        clr_lost = 1'b0;
        wait_release(n, seen);
        chk("relock2_edges", 32'(n), 32'(RH + 1));
        chk("relock2_lost",  32'(lost), 32'd1);

        // Async reset mid-RUN for under half a cycle
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_core_reset", 32'(core_reset), 32'd1);
        chk("arst_cen",        32'(cen),        32'd0);
        chk("arst_lost",       32'(lost),       32'd0);
        #2 rst_n = 1'b1;
        wait_release(n, seen);
        chk("arst_restart_edges", 32'(n), 32'(RH + 3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
